// File: rtl/tree_mem_loader_pkg.sv
// Shared types and constants for the tree memory loader: node layout, header
// fields and load FSM encoding.
package tree_pkg;

    localparam int HDR_NC_LSB = 0;
    localparam int HDR_NC_W   = 16;
    localparam int HDR_FC_LSB = 16;
    localparam int HDR_FC_W   = 16;

    localparam int NODE_VALUE_LSB = 32;
    localparam int NODE_RIGHT_LSB = 16;
    localparam int NODE_FIDX_LSB  = 8;
    localparam int NODE_KIND_BIT  = 0;

    typedef struct packed {
        logic [31:0] value;
        logic [7:0]  pad_hi;
        logic [7:0]  right_index;
        logic [7:0]  f_index;
        logic [6:0]  pad_lo;
        logic        leaf_or_node;  // 1 = decision, 0 = leaf
    } tree_camps_t;

    typedef logic [2:0] load_state_t;

    localparam load_state_t S_IDLE    = 3'd0;
    localparam load_state_t S_HEADER  = 3'd1;
    localparam load_state_t S_NODE_LO = 3'd2;
    localparam load_state_t S_NODE_HI = 3'd3;
    localparam load_state_t S_FEAT    = 3'd4;
    localparam load_state_t S_DRAIN   = 3'd5;

    function automatic logic is_decision(input tree_camps_t n);
        return n.leaf_or_node;
    endfunction

endpackage

// File: rtl/tree_mem_loader_if.sv
// 32-bit valid/ready load stream feeding the tree memory loader.
interface tree_mem_loader_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;

    modport master (output s_data, output s_valid, output s_last, input  s_ready);
    modport slave  (input  s_data, input  s_valid, input  s_last, output s_ready);
endinterface

// File: rtl/tree_mem_loader_sp_ram.sv
// One-write/one-read RAM with a registered read port; a same-cycle read of the
// address being written returns the previous contents.
module tree_sp_ram #(
    parameter int W     = 32,
    parameter int DEPTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tree_mem_loader.sv
// Loads tree nodes and features from a framed 32-bit stream into node/feature RAMs
// and serves the engine's registered lookups. Optional macro: TREE_LOAD_CHECK_EN.
module tree_mem_loader
    import tree_pkg::*;
#(
    parameter int N_NODE_AND_LEAFS = 256,
    parameter int N_FEATURE        = 32,
    localparam int NAW = $clog2(N_NODE_AND_LEAFS),
    localparam int FAW = $clog2(N_FEATURE)
) (
    input  logic               clk,
    input  logic               rst,
    tree_mem_loader_if.slave   s,
    input  logic [NAW-1:0]     node_index,
    output logic [63:0]        node,
    input  logic [FAW-1:0]     feature_index,
    output logic [31:0]        feature,
    output logic               loaded,
    output logic               load_error,
    output logic [15:0]        n_nodes
);

    load_state_t state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] faddr_q, faddr_d;
    logic [15:0] nc_q, nc_d;
    logic [15:0] fc_q, fc_d;
    logic        loaded_q, loaded_d;
    logic        err_q, err_d;

    logic        xfer;
    logic [15:0] hdr_nc;
    logic [15:0] hdr_fc;
    logic        hdr_bad;
    logic        last_node;
    logic        last_feat;
    logic        node_bad;
    tree_camps_t node_word;

    assign s.s_ready = (state_q != S_IDLE);
    assign xfer      = s.s_valid && s.s_ready;
    assign hdr_nc    = s.s_data[HDR_NC_LSB +: HDR_NC_W];
    assign hdr_fc    = s.s_data[HDR_FC_LSB +: HDR_FC_W];
    assign hdr_bad   = ({1'b0, hdr_nc} > 17'(N_NODE_AND_LEAFS)) ||
                       ({1'b0, hdr_fc} > 17'(N_FEATURE));
    assign last_node = (addr_q == nc_q - 16'd1);
    assign last_feat = (faddr_q == fc_q - 16'd1);
    assign node_word = {s.s_data, hold_q};

`ifdef TREE_LOAD_CHECK_EN
    // Right child must point forward and stay inside the tree; feature must exist.
    assign node_bad = is_decision(node_word) &&
                      (({8'd0, node_word.right_index} <= addr_q) ||
                       ({8'd0, node_word.right_index} >= nc_q)   ||
                       ({8'd0, node_word.f_index}     >= fc_q));
`else
    assign node_bad = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        addr_d   = addr_q;
        faddr_d  = faddr_q;
        nc_d     = nc_q;
        fc_d     = fc_q;
        loaded_d = loaded_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_HEADER;
            end

            S_HEADER: begin
                if (xfer) begin
                    loaded_d = 1'b0;
                    err_d    = 1'b0;
                    nc_d     = hdr_nc;
                    fc_d     = hdr_fc;
                    addr_d   = '0;
                    faddr_d  = '0;
                    if (hdr_bad) begin
                        err_d   = 1'b1;
                        state_d = s.s_last ? S_HEADER : S_DRAIN;
                    end else if (hdr_nc != 16'd0 || hdr_fc != 16'd0) begin
                        // More words expected: s_last here ends the load too early.
                        if (s.s_last) begin
                            err_d   = 1'b1;
                            state_d = S_HEADER;
                        end else begin
                            state_d = (hdr_nc != 16'd0) ? S_NODE_LO : S_FEAT;
                        end
                    end else if (s.s_last) begin
                        loaded_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
            end

            S_NODE_LO: begin
                if (xfer) begin
                    hold_d = s.s_data;
                    if (s.s_last) begin
                        err_d   = 1'b1;
                        state_d = S_HEADER;
                    end else begin
                        state_d = S_NODE_HI;
                    end
                end
            end

            S_NODE_HI: begin
                if (xfer) begin
                    addr_d = addr_q + 16'd1;
                    if (node_bad) begin
                        err_d   = 1'b1;
                        state_d = s.s_last ? S_HEADER : S_DRAIN;
                    end else if (!last_node || fc_q != 16'd0) begin
                        if (s.s_last) begin
                            err_d   = 1'b1;
                            state_d = S_HEADER;
                        end else begin
                            state_d = last_node ? S_FEAT : S_NODE_LO;
                        end
                    end else if (s.s_last) begin
                        loaded_d = 1'b1;
                        state_d  = S_HEADER;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
            end

            S_FEAT: begin
                if (xfer) begin
                    faddr_d = faddr_q + 16'd1;
                    if (!last_feat) begin
                        if (s.s_last) begin
                            err_d   = 1'b1;
                            state_d = S_HEADER;
                        end
                    end else if (s.s_last) begin
                        loaded_d = 1'b1;
                        state_d  = S_HEADER;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                if (xfer && s.s_last) begin
                    state_d = S_HEADER;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            hold_q   <= '0;
            addr_q   <= '0;
            faddr_q  <= '0;
            nc_q     <= '0;
            fc_q     <= '0;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            addr_q   <= addr_d;
            faddr_q  <= faddr_d;
            nc_q     <= nc_d;
            fc_q     <= fc_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
        end
    end

    tree_sp_ram #(
        .W     (64),
        .DEPTH (N_NODE_AND_LEAFS)
    ) u_node_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (xfer && (state_q == S_NODE_HI)),
        .waddr_i (addr_q[NAW-1:0]),
        .wdata_i (node_word),
        .raddr_i (node_index),
        .rdata_o (node)
    );

    tree_sp_ram #(
        .W     (32),
        .DEPTH (N_FEATURE)
    ) u_feat_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (xfer && (state_q == S_FEAT)),
        .waddr_i (faddr_q[FAW-1:0]),
        .wdata_i (s.s_data),
        .raddr_i (feature_index),
        .rdata_o (feature)
    );

    assign loaded     = loaded_q;
    assign load_error = err_q;
    assign n_nodes    = nc_q;

endmodule
